// File: rtl/ps2_device_tx_pkg.sv
// Shared PS/2 device-transmit definitions: frame length, FSM states, parity.
package ps2_device_tx_pkg;

    localparam int unsigned FRAME_LEN = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_GAP     = 2'd2,
        ST_INHIBIT = 2'd3
    } state_t;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO with peek-at-head and explicit pop; head stays put until popped.
module ps2_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [7:0]                     wr_data,
    input  logic                           pop,
    output logic [7:0]                     head,
    output logic [$clog2(DEPTH + 1)-1:0]   count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];
    assign w_wr  = wr_en && !full;
    assign w_rd  = pop && !empty;

    // Storage carries no reset; only pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// Keyboard-side PS/2 transmitter: buffers scan-code bytes and serialises them
// as 11-bit device-to-host frames, backing off whenever the host inhibits.
module ps2_device_tx
    import ps2_device_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned IDLE_GAP   = 100
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic [7:0]                          in_data,
    output logic                                in_ready,
    input  logic                                host_inhibit,
    output logic                                ps2_clk,
    output logic                                ps2_data,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH + 1)-1:0]   fifo_count
);

    localparam int unsigned CNT_MAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned BIT_W   = $clog2(FRAME_LEN);
    localparam int unsigned SHIFT_W = FRAME_LEN - 1;

    state_t             r_state,     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic               r_low,       w_low_nxt;
    logic [BIT_W-1:0]   r_bit_idx,   w_bit_nxt;
    logic [SHIFT_W-1:0] r_shift,     w_shift_nxt;
    logic               r_ps2_clk,   w_clk_nxt;
    logic               r_ps2_data,  w_data_nxt;

    logic [7:0]         w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_pop;
    logic               w_start;
    logic               w_can_start;
    logic               w_div_done;
    logic               w_last_bit;
    logic               w_abort;

    assign in_ready    = !w_full && !reset;
    assign w_wr        = in_valid && in_ready;
    assign w_can_start = !w_empty && !host_inhibit;
    assign w_div_done  = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit_idx == BIT_W'(FRAME_LEN - 1));
    // Once the stop bit's falling edge is issued the host has the frame.
    assign w_abort     = host_inhibit && !(w_last_bit && (r_low || w_div_done));

    assign ps2_clk     = r_ps2_clk;
    assign ps2_data    = r_ps2_data;
    assign busy        = (r_state != ST_IDLE) || (fifo_count != '0);

    ps2_tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_data (in_data),
        .pop     (w_pop),
        .head    (w_head),
        .count   (fifo_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_low      <= 1'b0;
            r_bit_idx  <= '0;
            r_shift    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_low      <= w_low_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_ps2_clk  <= w_clk_nxt;
            r_ps2_data <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_low_nxt   = r_low;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_clk_nxt   = r_ps2_clk;
        w_data_nxt  = r_ps2_data;
        w_pop       = 1'b0;
        w_start     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_start   = w_can_start;
            end
            ST_SEND: begin
                if (w_abort) begin
                    w_state_nxt = ST_INHIBIT;
                    w_cnt_nxt   = '0;
                    w_low_nxt   = 1'b0;
                    w_clk_nxt   = 1'b1;
                    w_data_nxt  = 1'b1;
                end else if (w_div_done) begin
                    w_cnt_nxt = '0;
                    if (!r_low) begin
                        w_low_nxt = 1'b1;
                        w_clk_nxt = 1'b0;
                    end else if (w_last_bit) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_GAP;
                        w_low_nxt   = 1'b0;
                        w_clk_nxt   = 1'b1;
                        w_data_nxt  = 1'b1;
                    end else begin
                        // Rising edge: present the next bit for a full high phase.
                        w_low_nxt   = 1'b0;
                        w_clk_nxt   = 1'b1;
                        w_data_nxt  = r_shift[0];
                        w_shift_nxt = {1'b1, r_shift[SHIFT_W-1:1]};
                        w_bit_nxt   = r_bit_idx + BIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(IDLE_GAP - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_can_start) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_INHIBIT: begin
                w_cnt_nxt = '0;
                if (!host_inhibit) begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Head byte is peeked here; it leaves the FIFO only on completion.
        if (w_start) begin
            w_state_nxt = ST_SEND;
            w_cnt_nxt   = '0;
            w_low_nxt   = 1'b0;
            w_bit_nxt   = '0;
            w_shift_nxt = {1'b1, odd_parity(w_head), w_head};
            w_clk_nxt   = 1'b1;
            w_data_nxt  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with a loopback PS/2 receiver and a byte scoreboard.
module tb_ps2_device_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int IDLE_GAP   = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       host_inhibit = 1'b0;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic [3:0] fifo_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  q_exp [$];
    logic [10:0] q_rx  [$];
    int          q_gap [$];

    int          rx_bits = 0;
    logic [10:0] rx_frame = '1;
    int          hi_run = 0;
    int          idle_run = 0;
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;

    ps2_device_tx #(
        .CLK_DIV      (CLK_DIV),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .IDLE_GAP     (IDLE_GAP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .host_inhibit (host_inhibit),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Loopback host receiver: samples data on each ps2_clk falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                rx_bits  = 0;
                hi_run   = 0;
                idle_run = 0;
            end else begin
                if (prev_clk && !ps2_clk) begin
                    rx_frame[rx_bits] = ps2_data;
                    rx_bits++;
                    if (rx_bits == 11) begin
                        q_rx.push_back(rx_frame);
                        rx_bits = 0;
                    end
                end
                if (prev_clk && prev_data && ps2_clk && !ps2_data && rx_bits == 0) begin
                    q_gap.push_back(idle_run);
                end
                idle_run = (ps2_clk && ps2_data) ? idle_run + 1 : 0;
                hi_run   = ps2_clk ? hi_run + 1 : 0;
                if (hi_run > CLK_DIV + 1) begin
                    rx_bits = 0;
                end
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic par;
        par = 1'b1;
        for (int i = 0; i < 8; i++) begin
            par = par ^ d[i];
        end
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the transfer.
    task automatic write_byte(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) begin
            check("wr_ready_timeout", 32'(in_ready), 32'd1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        q_exp.push_back(d);
    endtask

    task automatic drain(input int budget);
        int n;
        logic [7:0]  d;
        logic [10:0] f;
        n = 0;
        while (q_exp.size() > 0 && n < budget) begin
            @(negedge clock);
            n++;
            while (q_rx.size() > 0 && q_exp.size() > 0) begin
                d = q_exp.pop_front();
                f = q_rx.pop_front();
                check($sformatf("frame_%02h", d), 32'(f), 32'(exp_frame(d)));
            end
        end
        check("drain_pending", 32'(q_exp.size()), 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int lows;
        int g;
        logic [7:0] b3 [10];
        b3 = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
        check("rst_ps2_data", 32'(ps2_data), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Single byte 0x1C: latency, frame length, gap
        write_byte(8'h1C);
        check("t1_count", 32'(fifo_count), 32'd1);
        check("t1_pre_data", 32'(ps2_data), 32'd1);
        @(negedge clock);
        check("t1_start_bit", 32'(ps2_data), 32'd0);
        n = 0;
        while (fifo_count != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("t1_frame_len", 32'(n), 32'd88);
        n = 0;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("t1_gap_len", 32'(n), 32'd8);
        drain(50);

        // Back-to-back 0x00, 0xFF: parity 1 and an exact idle gap
        q_gap.delete();
        write_byte(8'h00);
        write_byte(8'hFF);
        drain(500);
        check("t2_gap_count", 32'(q_gap.size()), 32'd2);
        g = (q_gap.size() >= 2) ? q_gap[1] : -1;
        check("t2_gap_cycles", 32'(g), 32'd8);
        wait_idle("t2_idle", 100);

        // Ten bytes with in_valid held: backpressure at full
        for (int i = 0; i < 10; i++) begin
            write_byte(b3[i]);
            if (i == 7) begin
                check("t3_full_count", 32'(fifo_count), 32'd8);
                check("t3_full_ready", 32'(in_ready), 32'd0);
            end
        end
        drain(3000);
        wait_idle("t3_idle", 200);
        check("t3_no_dup", 32'(q_rx.size()), 32'd0);

        // Inhibit during data bit 4 of 0x5A: abort then retransmit once
        write_byte(8'h5A);
        n = 0;
        while (!(rx_bits == 5 && ps2_clk) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t4_reach_bit4", 32'(rx_bits), 32'd5);
        host_inhibit = 1'b1;
        @(negedge clock);
        check("t4_idle_clk", 32'(ps2_clk), 32'd1);
        check("t4_idle_data", 32'(ps2_data), 32'd1);
        lows = 0;
        repeat (19) begin
            @(negedge clock);
            if (!ps2_clk || !ps2_data) lows++;
        end
        check("t4_hold_idle", 32'(lows), 32'd0);
        check("t4_count_kept", 32'(fifo_count), 32'd1);
        host_inhibit = 1'b0;
        drain(400);
        wait_idle("t4_idle", 100);
        check("t4_single_rx", 32'(q_rx.size()), 32'd0);

        // Inhibit after the stop bit's falling edge: frame counts as sent
        write_byte(8'h33);
        n = 0;
        while (q_rx.size() == 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        host_inhibit = 1'b1;
        repeat (10) @(negedge clock);
        check("t5_popped", 32'(fifo_count), 32'd0);
        host_inhibit = 1'b0;
        repeat (150) @(negedge clock);
        drain(10);
        check("t5_no_retx", 32'(q_rx.size()), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);

        // Reset mid-frame with three bytes queued
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        n = 0;
        while (rx_bits != 3 && n < 200) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        @(negedge clock);
        check("t6_clk", 32'(ps2_clk), 32'd1);
        check("t6_data", 32'(ps2_data), 32'd1);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready_in_rst", 32'(in_ready), 32'd0);
        reset = 1'b0;
        q_exp.delete();
        @(negedge clock);
        check("t6_ready_after", 32'(in_ready), 32'd1);
        lows = 0;
        repeat (200) begin
            @(negedge clock);
            if (!ps2_clk || !ps2_data) lows++;
        end
        check("t6_line_quiet", 32'(lows), 32'd0);
        check("t6_no_frames", 32'(q_rx.size()), 32'd0);
        write_byte(8'hAB);
        drain(200);
        wait_idle("t6_recover_idle", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
